// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multi-cycle fetch/decode/execute sequencer for the datapath
//
// Purpose: latches ROM words into an internal IR and drives per-cycle datapath
// strobes. One instruction retires every 3 clocks (FETCH, DECODE, EXECUTE).
// Optional feature macro: CU_SINGLE_STEP_EN (adds step/waiting and a WAIT state).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   instr               ROM word at PC: opcode in MSBs, operand in LSBs
//   zero_flag/carry_flag registered ALU flags from the datapath
//   pc_inc, pc_load     PC increment / load strobes (load wins)
//   jump_target, imm    IR operand, resized to ADDR_WIDTH / as-is
//   a_we, a_src         register A write enable and source (0 ALU, 1 imm, 2 B)
//   b_we, b_src         register B write enable and source (0 A, 1 imm)
//   alu_sub, flags_we   ALU subtract select, flag latch strobe
//   out_we, halted      output register strobe, HALT indicator
//   step, waiting       single-step advance / WAIT indicator (macro builds only)

module cpu_control_unit #(
  parameter int BIT_WIDTH    = 4,
  parameter int ADDR_WIDTH   = BIT_WIDTH,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [OPCODE_WIDTH+BIT_WIDTH-1:0] instr,
  input  logic                              zero_flag,
  input  logic                              carry_flag,
`ifdef CU_SINGLE_STEP_EN
  input  logic                              step,
  output logic                              waiting,
`endif
  output logic                              pc_inc,
  output logic                              pc_load,
  output logic [ADDR_WIDTH-1:0]             jump_target,
  output logic [BIT_WIDTH-1:0]              imm,
  output logic                              a_we,
  output logic                              b_we,
  output logic [1:0]                        a_src,
  output logic                              b_src,
  output logic                              alu_sub,
  output logic                              flags_we,
  output logic                              out_we,
  output logic                              halted
);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_MAB = 4'h5;
  localparam logic [3:0] OP_MBA = 4'h6;
  localparam logic [3:0] OP_OUT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

`ifdef CU_SINGLE_STEP_EN
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_HALT, S_WAIT} state_t;
  localparam state_t S_RESET     = S_WAIT;
  localparam state_t S_AFTER_EXE = S_WAIT;
`else
  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_t;
  localparam state_t S_RESET     = S_FETCH;
  localparam state_t S_AFTER_EXE = S_FETCH;
`endif

  state_t                              state;
  logic [OPCODE_WIDTH+BIT_WIDTH-1:0]   ir;
  logic [OPCODE_WIDTH-1:0]             opcode;

  assign opcode = ir[OPCODE_WIDTH+BIT_WIDTH-1 -: OPCODE_WIDTH];
  assign imm    = ir[BIT_WIDTH-1:0];

  generate
    if (ADDR_WIDTH > BIT_WIDTH) begin : g_jt_ext
      assign jump_target = {{(ADDR_WIDTH-BIT_WIDTH){1'b0}}, imm};
    end else begin : g_jt_trunc
      assign jump_target = imm[ADDR_WIDTH-1:0];
    end
  endgenerate

  // pc_inc has to be high during the very first FETCH after reset release,
  // before any clock edge has occurred, so it is decoded from the state.
  // Gating with rst keeps it low while reset is held.
  assign pc_inc = rst && (state == S_FETCH);

`ifdef CU_SINGLE_STEP_EN
  assign waiting = (state == S_WAIT);
`endif

  // EXECUTE strobes are registered on the DECODE->EXECUTE edge, so they are
  // clean flop outputs for exactly the EXECUTE cycle. Branch flags are
  // captured on that edge; the datapath has settled them during DECODE and
  // they already include the previous ADD/SUB's flag update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_RESET;
      ir       <= '0;
      pc_load  <= 1'b0;
      a_we     <= 1'b0;
      b_we     <= 1'b0;
      a_src    <= 2'd0;
      b_src    <= 1'b0;
      alu_sub  <= 1'b0;
      flags_we <= 1'b0;
      out_we   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      pc_load  <= 1'b0;
      a_we     <= 1'b0;
      b_we     <= 1'b0;
      a_src    <= 2'd0;
      b_src    <= 1'b0;
      alu_sub  <= 1'b0;
      flags_we <= 1'b0;
      out_we   <= 1'b0;
      case (state)
        S_FETCH: begin
          ir    <= instr;
          state <= S_DECODE;
        end
        S_DECODE: begin
          state <= S_EXECUTE;
          case (opcode)
            OP_LDA: begin a_we <= 1'b1; a_src <= 2'd1; end
            OP_LDB: begin b_we <= 1'b1; b_src <= 1'b1; end
            OP_ADD: begin a_we <= 1'b1; flags_we <= 1'b1; end
            OP_SUB: begin a_we <= 1'b1; alu_sub <= 1'b1; flags_we <= 1'b1; end
            OP_MAB: b_we <= 1'b1;
            OP_MBA: begin a_we <= 1'b1; a_src <= 2'd2; end
            OP_OUT: out_we  <= 1'b1;
            OP_JMP: pc_load <= 1'b1;
            OP_JZ:  pc_load <= zero_flag;
            OP_JC:  pc_load <= carry_flag;
            default: ;
          endcase
        end
        S_EXECUTE: begin
          if (opcode == OP_HLT) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state  <= S_AFTER_EXE;
          end
        end
        S_HALT: state <= S_HALT;
`ifdef CU_SINGLE_STEP_EN
        S_WAIT: if (step) state <= S_FETCH;
`endif
        default: state <= S_RESET;
      endcase
    end
  end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Multi-cycle sequencer for the microprocessor datapath: fetches instruction words from program ROM, latches them into an internal IR, decodes the opcode, and drives per-cycle strobes to PC, register A/B, ALU, flags and output register.
- Sits inside top between ROM and datapath; one instruction retires every 3 clocks.

Parameters:
- BIT_WIDTH, 4, data/operand width; matches top BIT_WIDTH.
- ADDR_WIDTH, BIT_WIDTH, PC/ROM address width; jump target = operand zero-extended or truncated to ADDR_WIDTH.
- OPCODE_WIDTH, 4, opcode field width; fixed at 4, other values unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr  in  OPCODE_WIDTH+BIT_WIDTH  ROM data at current PC; opcode = MSBs, operand = LSBs.
- zero_flag  in  1  registered Z flag from datapath.
- carry_flag  in  1  registered C flag from datapath.
- pc_inc  out  1  PC += 1 at next edge.
- pc_load  out  1  PC <= jump_target at next edge; overrides pc_inc.
- jump_target  out  ADDR_WIDTH  IR operand resized.
- imm  out  BIT_WIDTH  IR operand.
- a_we  out  1  write register A.
- b_we  out  1  write register B.
- a_src  out  2  A write source: 0 ALU, 1 imm, 2 reg B.
- b_src  out  1  B write source: 0 reg A, 1 imm.
- alu_sub  out  1  0 add, 1 subtract (A op B).
- flags_we  out  1  latch ALU Z/C.
- out_we  out  1  out register <= A.
- halted  out  1  high in HALT state.

Behaviour:
- States (2-bit): FETCH -> DECODE -> EXECUTE -> FETCH; EXECUTE of HLT -> HALT. HALT terminal until rst low.
- Outputs: decoded from state register and IR only; no combinational input-to-output paths.
- Reset (rst low, async): state = FETCH, IR = 0; every strobe 0, halted 0, imm/jump_target 0. Reset mid-instruction aborts it; nothing further is written; the first edge after release is a FETCH.
- FETCH: IR <= instr at the edge; pc_inc = 1. No other strobe.
- DECODE: all strobes 0. This is the ROM/flag settle slot.
- EXECUTE: strobes per IR opcode, one cycle only.
  - 0 NOP: none.
  - 1 LDA: a_we, a_src = 1.
  - 2 LDB: b_we, b_src = 1.
  - 3 ADD: a_we, a_src = 0, alu_sub = 0, flags_we.
  - 4 SUB: same as ADD with alu_sub = 1.
  - 5 MAB: b_we, b_src = 0.
  - 6 MBA: a_we, a_src = 2.
  - 7 OUT: out_we.
  - 8 JMP: pc_load.
  - 9 JZ: pc_load if zero_flag.
  - A JC: pc_load if carry_flag.
  - B-E: reserved, treated as NOP.
  - F HLT: next state HALT.
- Flags for JZ/JC are sampled in EXECUTE. They reflect the most recent ADD/SUB, because flags_we lands at the end of that instruction's EXECUTE.
- PC wrap: increments past 2^ADDR_WIDTH-1 wrap to 0. The controller does not detect wrap.
- Don't-care defaults: a_src, b_src and alu_sub are 0 whenever their write enable is 0.
- HALT: all strobes 0, halted = 1, IR held, instr ignored.

Optional Feature:
- Macro: CU_SINGLE_STEP_EN.
- When defined:
  - Adds input `step` (1 bit) and a WAIT state.
  - EXECUTE (non-HLT) -> WAIT. WAIT -> FETCH on the first cycle step = 1; step held high advances one instruction per 4 cycles.
  - Adds output `waiting` (1 in WAIT). Reset enters WAIT instead of FETCH.
  - HLT still goes to HALT.
- When undefined: no step/waiting ports; 3-cycle flow exactly as above.

Test Plan:
- Reset: hold rst = 0 for 2 edges with instr = 8'h1F. Required: all strobes 0, halted 0. Release: cycle 1 pc_inc = 1, cycle 2 idle, cycle 3 a_we = 1, a_src = 1, imm = 4'hF.
- Arithmetic: program LDA 3, LDB 4, ADD, OUT. Required: add strobe (a_we, a_src = 0, alu_sub = 0, flags_we) in the 9th cycle; out_we in the 12th; exactly one pc_inc per instruction.
- Branches: JZ 5 with zero_flag = 0 -> no pc_load. With zero_flag = 1 -> pc_load = 1, jump_target = 5. JC 9 with carry_flag = 1 -> pc_load, jump_target = 9.
- Halt: HLT (8'hF0) -> halted = 1 from the cycle after its EXECUTE. 20 further cycles with random instr: zero strobes. rst pulse -> FETCH resumes.
- Reset mid-op: assert rst during the DECODE of an ADD. Required: no a_we/flags_we ever issued for that ADD; restart in FETCH.
- CU_SINGLE_STEP_EN: step = 0 for 10 cycles after reset -> waiting = 1, pc_inc never asserted. One-cycle step pulse -> exactly one instruction executed, then waiting = 1 again.
